// File: rtl/uart_regs_param.sv
// -----------------------------------------------------------------------------
// uart_regs_param
//   Parameterised UART register file sitting between the register bridge and
//   the UART TX/RX datapaths. Holds the line configuration, baud divisor,
//   FIFO watermarks, interrupt enable/status, and a one-byte RX prefetch
//   holding register so RX_DATA reads return data with no wait state.
//
// Optional feature macro:
//   UART_RX_TIMEOUT_EN  - enables the RX_TIMEOUT register (addr 8), the
//                         idle-line counter and INT_STATUS/INT_ENABLE bit 5.
//                         When undefined, addr 8 reads 0 and ignores writes.
//
// Ports:
//   uart_clk, rst                  clock, synchronous active-high reset
//   reg_addr/wdata/wen/ren         register bus (word address, 1-cycle strobes)
//   reg_rdata, reg_error           combinational read data / access error
//   wr_data, wr_en                 TX FIFO push
//   tx_full/empty/active, tx_level TX path state
//   rx_data, rd_en                 RX FIFO pop (data valid the cycle after)
//   rx_empty/full/active, rx_level RX path state
//   frame/parity/overrun_error     one-cycle error pulses from the receiver
//   baud_tick                      one pulse per bit time
//   baud_divisor, baud_enable      baud generator control
//   data_bits, parity_en, parity_odd, stop2   line configuration
//   tx_fifo_rst, rx_fifo_rst       self-clearing FIFO reset pulses
//   irq                            level interrupt
// -----------------------------------------------------------------------------
module uart_regs_param #(
  parameter int DATA_WIDTH      = 32,
  parameter int FIFO_ADDR_WIDTH = 3,
  parameter int DIV_WIDTH       = 16,
  parameter int DIV_RESET       = 4
) (
  input  logic                       uart_clk,
  input  logic                       rst,
  input  logic [3:0]                 reg_addr,
  input  logic [DATA_WIDTH-1:0]      reg_wdata,
  input  logic                       reg_wen,
  input  logic                       reg_ren,
  output logic [DATA_WIDTH-1:0]      reg_rdata,
  output logic                       reg_error,
  output logic [7:0]                 wr_data,
  output logic                       wr_en,
  input  logic                       tx_full,
  input  logic                       tx_empty,
  input  logic                       tx_active,
  input  logic [FIFO_ADDR_WIDTH:0]   tx_level,
  input  logic [7:0]                 rx_data,
  output logic                       rd_en,
  input  logic                       rx_empty,
  input  logic                       rx_full,
  input  logic                       rx_active,
  input  logic [FIFO_ADDR_WIDTH:0]   rx_level,
  input  logic                       frame_error,
  input  logic                       parity_error,
  input  logic                       overrun_error,
  input  logic                       baud_tick,
  output logic [DIV_WIDTH-1:0]       baud_divisor,
  output logic                       baud_enable,
  output logic [1:0]                 data_bits,
  output logic                       parity_en,
  output logic                       parity_odd,
  output logic                       stop2,
  output logic                       tx_fifo_rst,
  output logic                       rx_fifo_rst,
  output logic                       irq
);

  localparam logic [3:0] ADDR_CTRL       = 4'd0;
  localparam logic [3:0] ADDR_STATUS     = 4'd1;
  localparam logic [3:0] ADDR_TX_DATA    = 4'd2;
  localparam logic [3:0] ADDR_RX_DATA    = 4'd3;
  localparam logic [3:0] ADDR_BAUD_DIV   = 4'd4;
  localparam logic [3:0] ADDR_INT_ENABLE = 4'd5;
  localparam logic [3:0] ADDR_INT_STATUS = 4'd6;
  localparam logic [3:0] ADDR_FIFO_CTRL  = 4'd7;
  localparam logic [3:0] ADDR_RX_TIMEOUT = 4'd8;

`ifdef UART_RX_TIMEOUT_EN
  localparam logic [5:0] INT_MASK = 6'h3F;
`else
  localparam logic [5:0] INT_MASK = 6'h1F;
`endif

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_READY} rx_state_t;

  // Register state
  logic       tx_en, rx_en;
  logic [5:0] int_enable, int_status, int_set;
  logic [3:0] tx_thr, rx_thr;
  logic       fe_sticky, pe_sticky, oe_sticky;
  logic [7:0] rx_hold;
  logic [7:0] rx_timeout_rd;
  logic       timeout_hit;
  rx_state_t  rx_state, rx_state_next;
  logic       rx_valid;

  // Decoded strobes
  logic wr_ctrl, wr_baud, wr_int_en, wr_int_st, wr_fifo, wr_tx, rd_rx;
  logic [5:0] w1c;

  assign wr_ctrl   = reg_wen && (reg_addr == ADDR_CTRL);
  assign wr_baud   = reg_wen && (reg_addr == ADDR_BAUD_DIV);
  assign wr_int_en = reg_wen && (reg_addr == ADDR_INT_ENABLE);
  assign wr_int_st = reg_wen && (reg_addr == ADDR_INT_STATUS);
  assign wr_fifo   = reg_wen && (reg_addr == ADDR_FIFO_CTRL);
  assign wr_tx     = reg_wen && (reg_addr == ADDR_TX_DATA);
  assign rd_rx     = reg_ren && (reg_addr == ADDR_RX_DATA);
  assign w1c       = wr_int_st ? reg_wdata[5:0] : 6'd0;

  assign rx_valid    = (rx_state == S_READY);
  assign baud_enable = tx_en | rx_en;
  assign irq         = |(int_status & int_enable);

  // TX push goes straight through; a full FIFO drops the byte.
  assign wr_data = reg_wdata[7:0];
  assign wr_en   = !rst && wr_tx && !tx_full;

  // ---------------------------------------------------------------------------
  // Configuration registers
  // ---------------------------------------------------------------------------
  // NOTE: every clocked block uses non-blocking assignments so all registers
  // update together from pre-edge values; blocking here would create order-
  // dependent simulation and mismatch synthesis.
  always_ff @(posedge uart_clk) begin
    if (rst) begin
      tx_en        <= 1'b0;
      rx_en        <= 1'b0;
      data_bits    <= 2'b11;
      parity_en    <= 1'b0;
      parity_odd   <= 1'b0;
      stop2        <= 1'b0;
      baud_divisor <= DIV_WIDTH'(DIV_RESET);
      int_enable   <= 6'd0;
      tx_thr       <= 4'd0;
      rx_thr       <= 4'd0;
      tx_fifo_rst  <= 1'b0;
      rx_fifo_rst  <= 1'b0;
    end else begin
      // Reset bits are not stored: they produce a single pulse and read 0.
      tx_fifo_rst <= wr_fifo && reg_wdata[0];
      rx_fifo_rst <= wr_fifo && reg_wdata[1];
      if (wr_ctrl) begin
        tx_en      <= reg_wdata[0];
        rx_en      <= reg_wdata[1];
        data_bits  <= reg_wdata[3:2];
        parity_en  <= reg_wdata[4];
        parity_odd <= reg_wdata[5];
        stop2      <= reg_wdata[6];
      end
      if (wr_baud)   baud_divisor <= reg_wdata[DIV_WIDTH-1:0];
      if (wr_int_en) int_enable   <= reg_wdata[5:0] & INT_MASK;
      if (wr_fifo) begin
        tx_thr <= reg_wdata[11:8];
        rx_thr <= reg_wdata[19:16];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Interrupt status and sticky error flags: a same-cycle set beats W1C.
  // ---------------------------------------------------------------------------
  logic [8:0] tx_level_x, rx_sum, rx_thr_eff;
  assign tx_level_x = 9'(tx_level);
  assign rx_sum     = 9'(rx_level) + 9'(rx_valid);
  assign rx_thr_eff = (rx_thr == 4'd0) ? 9'd1 : 9'(rx_thr);

  // NOTE: combinational blocks assign a default to every output first so no
  // path leaves a value unassigned, which would infer a latch.
  always_comb begin
    int_set    = 6'd0;
    int_set[0] = tx_en && (tx_level_x <= 9'(tx_thr));
    int_set[1] = rx_en && (rx_sum >= rx_thr_eff);
    int_set[2] = frame_error;
    int_set[3] = parity_error;
    int_set[4] = overrun_error;
    int_set[5] = timeout_hit;
  end

  always_ff @(posedge uart_clk) begin
    if (rst) begin
      int_status <= 6'd0;
      fe_sticky  <= 1'b0;
      pe_sticky  <= 1'b0;
      oe_sticky  <= 1'b0;
    end else begin
      int_status <= (int_set | (int_status & ~w1c)) & INT_MASK;
      fe_sticky  <= frame_error   | (fe_sticky & ~w1c[2]);
      pe_sticky  <= parity_error  | (pe_sticky & ~w1c[3]);
      oe_sticky  <= overrun_error | (oe_sticky & ~w1c[4]);
    end
  end

  // ---------------------------------------------------------------------------
  // RX prefetch FSM: keeps one byte ready so RX_DATA reads return immediately.
  // ---------------------------------------------------------------------------
  always_ff @(posedge uart_clk) begin
    if (rst) rx_state <= S_IDLE;
    else     rx_state <= rx_state_next;
  end

  always_comb begin
    rx_state_next = rx_state;
    if (rx_fifo_rst) begin
      rx_state_next = S_IDLE;
    end else begin
      case (rx_state)
        S_IDLE:  if (!rx_empty) rx_state_next = S_FETCH;
        S_FETCH: rx_state_next = S_READY;
        S_READY: if (rd_rx) rx_state_next = rx_empty ? S_IDLE : S_FETCH;
        default: rx_state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_en = 1'b0;
    if (!rst && !rx_fifo_rst && !rx_empty) begin
      case (rx_state)
        S_IDLE:  rd_en = 1'b1;
        S_READY: rd_en = rd_rx;
        default: rd_en = 1'b0;
      endcase
    end
  end

  // NOTE: the holding byte is a plain register, so it is reset; a reset in
  // the middle of a transfer must not expose a stale byte.
  always_ff @(posedge uart_clk) begin
    if (rst)                      rx_hold <= 8'd0;
    else if (rx_state == S_FETCH) rx_hold <= rx_data;
  end

  // ---------------------------------------------------------------------------
  // RX idle timeout
  // ---------------------------------------------------------------------------
`ifdef UART_RX_TIMEOUT_EN
  logic [7:0] rx_timeout, to_cnt;
  logic       wr_timeout, to_clr, to_inc;

  assign wr_timeout = reg_wen && (reg_addr == ADDR_RX_TIMEOUT);
  assign to_clr     = rd_rx || rx_active || rx_fifo_rst || wr_timeout;
  // Counter parks at RX_TIMEOUT, so the interrupt fires once per idle period.
  assign to_inc     = baud_tick && rx_valid && !rx_active &&
                      (rx_timeout != 8'd0) && (to_cnt != rx_timeout);
  assign timeout_hit = !to_clr && to_inc && ((to_cnt + 8'd1) == rx_timeout);
  assign rx_timeout_rd = rx_timeout;

  always_ff @(posedge uart_clk) begin
    if (rst) begin
      rx_timeout <= 8'd0;
      to_cnt     <= 8'd0;
    end else begin
      if (wr_timeout) rx_timeout <= reg_wdata[7:0];
      if (to_clr)      to_cnt <= 8'd0;
      else if (to_inc) to_cnt <= to_cnt + 8'd1;
    end
  end
`else
  assign timeout_hit   = 1'b0;
  assign rx_timeout_rd = 8'd0;
`endif

  // ---------------------------------------------------------------------------
  // Read mux and access errors
  // ---------------------------------------------------------------------------
  logic [31:0] rdata32;

  always_comb begin
    rdata32 = 32'd0;
    case (reg_addr)
      ADDR_CTRL:       rdata32 = {25'd0, stop2, parity_odd, parity_en,
                                  data_bits, rx_en, tx_en};
      ADDR_STATUS:     rdata32 = {8'(tx_level), 8'(rx_level), 7'd0,
                                  oe_sticky, pe_sticky, fe_sticky,
                                  rx_active, tx_active, rx_full, rx_empty,
                                  tx_full, tx_empty};
      ADDR_RX_DATA:    rdata32 = rx_valid ? {23'd0, 1'b1, rx_hold} : 32'd0;
      ADDR_BAUD_DIV:   rdata32 = 32'(baud_divisor);
      ADDR_INT_ENABLE: rdata32 = {26'd0, int_enable};
      ADDR_INT_STATUS: rdata32 = {26'd0, int_status};
      ADDR_FIFO_CTRL:  rdata32 = {12'd0, rx_thr, 4'd0, tx_thr, 8'd0};
      ADDR_RX_TIMEOUT: rdata32 = {24'd0, rx_timeout_rd};
      default:         rdata32 = 32'd0;
    endcase
  end

  assign reg_rdata = DATA_WIDTH'(rdata32);

  always_comb begin
    reg_error = 1'b0;
    if (reg_wen || reg_ren) begin
      if (reg_addr > ADDR_RX_TIMEOUT)
        reg_error = 1'b1;
      else if (reg_wen && (reg_addr == ADDR_STATUS || reg_addr == ADDR_RX_DATA))
        reg_error = 1'b1;
      else if (reg_wen && reg_addr == ADDR_TX_DATA && tx_full)
        reg_error = 1'b1;
      else if (reg_ren && reg_addr == ADDR_TX_DATA)
        reg_error = 1'b1;
      else if (rd_rx && !rx_valid)
        reg_error = 1'b1;
    end
  end

  // Write-data bits outside the defined fields and, in the default build,
  // the baud tick are intentionally ignored.
  logic unused_ok;
  assign unused_ok = ^{reg_wdata, baud_tick};

endmodule

// File: tb/tb_uart_regs_param.sv
module tb_uart_regs_param;

  localparam logic [3:0] A_CTRL = 4'd0, A_STATUS = 4'd1, A_TX = 4'd2,
                         A_RX = 4'd3, A_BAUD = 4'd4, A_INTEN = 4'd5,
                         A_INTST = 4'd6, A_FIFO = 4'd7, A_TO = 4'd8;

  logic        uart_clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  reg_addr = 4'd0;
  logic [31:0] reg_wdata = 32'd0;
  logic        reg_wen = 1'b0, reg_ren = 1'b0;
  logic [31:0] reg_rdata;
  logic        reg_error;
  logic [7:0]  wr_data;
  logic        wr_en;
  logic        tx_full = 1'b0, tx_empty = 1'b1, tx_active = 1'b0;
  logic [3:0]  tx_level = 4'd0;
  logic [7:0]  rx_data = 8'd0;
  logic        rd_en;
  logic        rx_empty = 1'b1, rx_full = 1'b0, rx_active = 1'b0;
  logic [3:0]  rx_level = 4'd0;
  logic        frame_error = 1'b0, parity_error = 1'b0, overrun_error = 1'b0;
  logic        baud_tick = 1'b0;
  logic [15:0] baud_divisor;
  logic        baud_enable;
  logic [1:0]  data_bits;
  logic        parity_en, parity_odd, stop2;
  logic        tx_fifo_rst, rx_fifo_rst, irq;

  uart_regs_param #(
    .DATA_WIDTH(32), .FIFO_ADDR_WIDTH(3), .DIV_WIDTH(16), .DIV_RESET(4)
  ) dut (
    .uart_clk(uart_clk), .rst(rst),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wen(reg_wen), .reg_ren(reg_ren),
    .reg_rdata(reg_rdata), .reg_error(reg_error),
    .wr_data(wr_data), .wr_en(wr_en),
    .tx_full(tx_full), .tx_empty(tx_empty), .tx_active(tx_active), .tx_level(tx_level),
    .rx_data(rx_data), .rd_en(rd_en),
    .rx_empty(rx_empty), .rx_full(rx_full), .rx_active(rx_active), .rx_level(rx_level),
    .frame_error(frame_error), .parity_error(parity_error), .overrun_error(overrun_error),
    .baud_tick(baud_tick),
    .baud_divisor(baud_divisor), .baud_enable(baud_enable),
    .data_bits(data_bits), .parity_en(parity_en), .parity_odd(parity_odd), .stop2(stop2),
    .tx_fifo_rst(tx_fifo_rst), .rx_fifo_rst(rx_fifo_rst), .irq(irq)
  );

  always #5 uart_clk = ~uart_clk;

  // ---------------------------------------------------------------------------
  // RX FIFO model: registered empty/level, data valid the cycle after rd_en.
  // ---------------------------------------------------------------------------
  logic [7:0] rx_q[$];
  logic       push_v = 1'b0;
  logic [7:0] push_b = 8'd0;
  int         rd_en_cnt = 0, pop_empty_cnt = 0, rx_rst_cnt = 0, tx_rst_cnt = 0;

  always @(posedge uart_clk) begin
    if (tx_fifo_rst) tx_rst_cnt <= tx_rst_cnt + 1;
    if (rx_fifo_rst) begin
      rx_q.delete();
      rx_rst_cnt <= rx_rst_cnt + 1;
    end else begin
      if (rd_en) begin
        rd_en_cnt <= rd_en_cnt + 1;
        if (rx_q.size() == 0) pop_empty_cnt <= pop_empty_cnt + 1;
        else                  rx_data <= rx_q.pop_front();
      end
      if (push_v) rx_q.push_back(push_b);
    end
    rx_empty <= (rx_q.size() == 0);
    rx_level <= 4'(rx_q.size());
  end

  // ---------------------------------------------------------------------------
  // Scoreboard and counters
  // ---------------------------------------------------------------------------
  logic [31:0] exp_q[$];
  logic [31:0] got, want;
  int          n_checks = 0, n_pass = 0;

  // ---------------------------------------------------------------------------
  // Bus and stimulus tasks
  // ---------------------------------------------------------------------------
  task automatic bus_write(input logic [3:0] a, input logic [31:0] d,
                           output logic err, output logic we, output logic [7:0] wd);
    @(posedge uart_clk); #1;
    reg_addr = a; reg_wdata = d; reg_wen = 1'b1;
    @(negedge uart_clk);
    err = reg_error; we = wr_en; wd = wr_data;
    @(posedge uart_clk); #1;
    reg_wen = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d, output logic err);
    @(posedge uart_clk); #1;
    reg_addr = a; reg_ren = 1'b1;
    @(negedge uart_clk);
    d = reg_rdata; err = reg_error;
    @(posedge uart_clk); #1;
    reg_ren = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    logic e, w;
    logic [7:0] b;
    bus_write(a, d, e, w, b);
  endtask

  task automatic push_byte(input logic [7:0] b);
    @(posedge uart_clk); #1;
    push_v = 1'b1; push_b = b;
    @(posedge uart_clk); #1;
    push_v = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge uart_clk);
    #1;
  endtask

  task automatic tick;
    @(posedge uart_clk); #1; baud_tick = 1'b1;
    @(posedge uart_clk); #1; baud_tick = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset;
    logic [31:0] d; logic e;
    @(negedge uart_clk);
    exp_q.push_back(32'd0);
    got = {30'd0, irq, rd_en}; want = exp_q.pop_front(); n_checks++;
    if (got !== want) $display("FAIL reset_irq_rden: got %h expected %h", got, want);
    else n_pass++;

    exp_q.push_back({13'd0, 16'h0004, 2'b11, 1'b0});
    got = {13'd0, baud_divisor, data_bits, baud_enable}; want = exp_q.pop_front(); n_checks++;
    if (got !== want) $display("FAIL reset_outputs: got %h expected %h", got, want);
    else n_pass++;

    exp_q.push_back(32'h0000_000C);
    bus_read(A_CTRL, d, e);
    got = d; want = exp_q.pop_front(); n_checks++;
    if (got !== want) $display("FAIL reset_ctrl: got %h expected %h", got, want);
    else n_pass++;

    exp_q.push_back(32'h0000_0004);
    bus_read(A_BAUD, d, e);
    got = d; want = exp_q.pop_front(); n_checks++;
    if (got !== want) $display("FAIL reset_baud: got %h expected %h", got, want);
    else n_pass++;

    exp_q.push_back(32'h0000_0005);
    bus_read(A_STATUS, d, e);
    got = d; want = exp_q.pop_front(); n_checks++;
    if (got !== want) $display("FAIL reset_status: got %h expected %h", got, want);
    else n_pass++;
  endtask

  task automatic test_ctrl_baud;
    logic [31:0] d; logic e;
    wr(A_CTRL, 32'h0000_0001);
    @(negedge uart_clk);
    exp_q.push_back({29'd0, 2'b00, 1'b1});
    got = {29'd0, data_bits, baud_enable}; want = exp_q.pop_front(); n_checks++;
    if (got !== want) $display("FAIL ctrl_baud_enable: got %h expected %h", got, want);
    else n_pass++;

    wr(A_BAUD, 32'h0000_001B);
    @(negedge uart_clk);
    exp_q.push_back(32'h0000_001B);
    got = {16'd0, baud_divisor}; want = exp_q.pop_front(); n_checks++;
    if (got !== want) $display("FAIL baud_divisor: got %h expected %h", got, want);
    else n_pass++;

    wr(A_BAUD, 32'hFFFF_FFFF);
    exp_q.push_back(32'h0000_FFFF);
    bus_read(A_BAUD, d, e);
    got = d; want = exp_q.pop_front(); n_checks++;
    if (got !== want) $display("FAIL baud_width: got %h expected %h", got, want);
    else n_pass++;
    wr(A_BAUD, 32'h0000_001B);
  endtask

  task automatic test_tx;
    logic e, w; logic [7:0] b;
    exp_q.push_back({22'd0, 1'b0, 1'b1, 8'hA5});
    bus_write(A_TX, 32'h0000_03A5, e, w, b);
    got = {22'd0, e, w, b}; want = exp_q.pop_front(); n_checks++;
    if (got !== want) $display("FAIL tx_push: got %h expected %h", got, want);
    else n_pass++;

    tx_full = 1'b1;
    exp_q.push_back({30'd0, 1'b1, 1'b0});
    bus_write(A_TX, 32'h0000_0055, e, w, b);
    got = {30'd0, e, w}; want = exp_q.pop_front(); n_checks++;
    if (got !== want) $display("FAIL tx_full_drop: got %h expected %h", got, want);
    else n_pass++;
    tx_full = 1'b0;
  endtask

  task automatic test_rx_single;
    logic [31:0] d; logic e;
    int rd0;
    rd0 = rd_en_cnt;
    push_byte(8'hA5);
    idle(4);
    exp_q.push_back(32'd1);
    got = 32'(rd_en_cnt - rd0); want = exp_q.pop_front(); n_checks++;
    if (got !== want) $display("FAIL rx_rd_en_once: got %0d expected %0d", got, want);
    else n_pass++;

    exp_q.push_back({32'h0000_01A5});
    bus_read(A_RX, d, e);
    got = {e, d[30:0]}; want = exp_q.pop_front(); n_checks++;
    if (got !== want) $display("FAIL rx_first_read: got %h expected %h", got, want);
    else n_pass++;

    exp_q.push_back(32'h8000_0000);
    bus_read(A_RX, d, e);
    got = {e, d[30:0]}; want = exp_q.pop_front(); n_checks++;
    if (got !== want) $display("FAIL rx_empty_read: got %h expected %h (bit31=error)", got, want);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [31:0] d; logic e;
    int rd0, pe0;
    logic [7:0] bytes [3];
    bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33;
    rd0 = rd_en_cnt; pe0 = pop_empty_cnt;
    for (int i = 0; i < 3; i++) push_byte(bytes[i]);
    idle(4);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({23'd0, 1'b1, bytes[i]});
      bus_read(A_RX, d, e);
      got = {e, d[30:0]}; want = exp_q.pop_front(); n_checks++;
      if (got !== want) $display("FAIL b2b_read%0d: got %h expected %h", i, got, want);
      else n_pass++;
    end
    exp_q.push_back(32'h8000_0000);
    bus_read(A_RX, d, e);
    got = {e, d[30:0]}; want = exp_q.pop_front(); n_checks++;
    if (got !== want) $display("FAIL b2b_drained: got %h expected %h", got, want);
    else n_pass++;

    exp_q.push_back({16'd3, 16'd0});
    got = {16'(rd_en_cnt - rd0), 16'(pop_empty_cnt - pe0)}; want = exp_q.pop_front(); n_checks++;
    if (got !== want) $display("FAIL b2b_pops: got %h expected %h (pops,empty_pops)", got, want);
    else n_pass++;
  endtask

  task automatic test_errors;
    logic [31:0] d; logic e, w; logic [7:0] b;
    exp_q.push_back({1'b1, 31'd0});
    bus_read(4'd9, d, e);
    got = {e, d[30:0]}; want = exp_q.pop_front(); n_checks++;
    if (got !== want) $display("FAIL err_addr9: got %h expected %h", got, want);
    else n_pass++;

    exp_q.push_back(32'b1101);
    bus_write(A_STATUS, 32'hFFFF_FFFF, e, w, b);
    got[3] = e;
    bus_write(A_RX, 32'hFFFF_FFFF, e, w, b);
    got[2] = e;
    bus_write(A_CTRL, 32'h0000_0001, e, w, b);
    got[1] = e;
    bus_read(A_TX, d, e);
    got[0] = e;
    got[31:4] = 28'd0; want = exp_q.pop_front(); n_checks++;
    if (got !== want) $display("FAIL err_map: got %b expected %b", got[3:0], want[3:0]);
    else n_pass++;

`ifdef UART_RX_TIMEOUT_EN
    exp_q.push_back(32'h0000_00FF);
`else
    exp_q.push_back(32'h0000_0000);
`endif
    bus_write(A_TO, 32'h0000_00FF, e, w, b);
    bus_read(A_TO, d, got[31]);
    got = {e | got[31], d[30:0]}; want = exp_q.pop_front(); n_checks++;
    if (got !== want) $display("FAIL timeout_reg: got %h expected %h", got, want);
    else n_pass++;
    wr(A_TO, 32'd0);

`ifdef UART_RX_TIMEOUT_EN
    exp_q.push_back(32'h0000_003F);
`else
    exp_q.push_back(32'h0000_001F);
`endif
    wr(A_INTEN, 32'hFFFF_FFFF);
    bus_read(A_INTEN, d, e);
    got = d; want = exp_q.pop_front(); n_checks++;
    if (got !== want) $display("FAIL int_enable_mask: got %h expected %h", got, want);
    else n_pass++;
    wr(A_INTEN, 32'd0);
  endtask

  task automatic test_fifo_ctrl;
    logic [31:0] d; logic e;
    int rr0, tr0;
    rr0 = rx_rst_cnt; tr0 = tx_rst_cnt;
    wr(A_FIFO, 32'h0005_0303);
    idle(2);
    exp_q.push_back({16'd1, 16'd1});
    got = {16'(rx_rst_cnt - rr0), 16'(tx_rst_cnt - tr0)}; want = exp_q.pop_front(); n_checks++;
    if (got !== want) $display("FAIL fifo_rst_pulse: got %h expected %h", got, want);
    else n_pass++;

    exp_q.push_back(32'h0005_0300);
    bus_read(A_FIFO, d, e);
    got = d; want = exp_q.pop_front(); n_checks++;
    if (got !== want) $display("FAIL fifo_ctrl_read: got %h expected %h", got, want);
    else n_pass++;
  endtask

  task automatic test_watermarks;
    logic [31:0] d; logic e;
    tx_level = 4'd5;
    wr(A_FIFO, 32'h0002_0300);
    wr(A_INTST, 32'h3F);
    exp_q.push_back(32'h0);
    bus_read(A_INTST, d, e);
    got = d & 32'h3; want = exp_q.pop_front(); n_checks++;
    if (got !== want) $display("FAIL tx_low_above: got %h expected %h", got, want);
    else n_pass++;

    tx_level = 4'd3;
    idle(2);
    exp_q.push_back(32'h1);
    bus_read(A_INTST, d, e);
    got = d & 32'h1; want = exp_q.pop_front(); n_checks++;
    if (got !== want) $display("FAIL tx_low_equal: got %h expected %h", got, want);
    else n_pass++;

    wr(A_CTRL, 32'h0000_0003);
    push_byte(8'h77);
    idle(4);
    wr(A_INTST, 32'h02);
    exp_q.push_back(32'h0);
    bus_read(A_INTST, d, e);
    got = d & 32'h2; want = exp_q.pop_front(); n_checks++;
    if (got !== want) $display("FAIL rx_high_below: got %h expected %h", got, want);
    else n_pass++;

    push_byte(8'h88);
    idle(2);
    exp_q.push_back(32'h2);
    bus_read(A_INTST, d, e);
    got = d & 32'h2; want = exp_q.pop_front(); n_checks++;
    if (got !== want) $display("FAIL rx_high_reached: got %h expected %h", got, want);
    else n_pass++;

    bus_read(A_RX, d, e);
    bus_read(A_RX, d, e);
    exp_q.push_back(32'h0000_0188);
    got = d; want = exp_q.pop_front(); n_checks++;
    if (got !== want) $display("FAIL rx_drain: got %h expected %h", got, want);
    else n_pass++;

    wr(A_CTRL, 32'h0000_0001);
    tx_level = 4'd0;
    wr(A_FIFO, 32'h0);
    wr(A_INTST, 32'h3F);
  endtask

  task automatic test_parity_irq;
    logic [31:0] d; logic e;
    wr(A_INTEN, 32'h08);
    wr(A_INTST, 32'h3F);
    @(negedge uart_clk);
    exp_q.push_back(32'd0);
    got = {31'd0, irq}; want = exp_q.pop_front(); n_checks++;
    if (got !== want) $display("FAIL irq_idle: got %h expected %h", got, want);
    else n_pass++;

    @(posedge uart_clk); #1; parity_error = 1'b1;
    @(posedge uart_clk); #1; parity_error = 1'b0;
    @(negedge uart_clk);
    exp_q.push_back(32'd1);
    got = {31'd0, irq}; want = exp_q.pop_front(); n_checks++;
    if (got !== want) $display("FAIL pe_irq: got %h expected %h", got, want);
    else n_pass++;

    exp_q.push_back(32'h80);
    bus_read(A_STATUS, d, e);
    got = d & 32'h80; want = exp_q.pop_front(); n_checks++;
    if (got !== want) $display("FAIL pe_sticky: got %h expected %h", got, want);
    else n_pass++;

    // W1C collides with a fresh pulse: the set must win.
    @(posedge uart_clk); #1;
    reg_addr = A_INTST; reg_wdata = 32'h08; reg_wen = 1'b1; parity_error = 1'b1;
    @(posedge uart_clk); #1;
    reg_wen = 1'b0; parity_error = 1'b0;
    @(negedge uart_clk);
    exp_q.push_back(32'd1);
    got = {31'd0, irq}; want = exp_q.pop_front(); n_checks++;
    if (got !== want) $display("FAIL pe_set_wins: got %h expected %h", got, want);
    else n_pass++;

    wr(A_INTST, 32'h08);
    @(negedge uart_clk);
    exp_q.push_back(32'd0);
    got = {31'd0, irq}; want = exp_q.pop_front(); n_checks++;
    if (got !== want) $display("FAIL pe_w1c_irq: got %h expected %h", got, want);
    else n_pass++;

    exp_q.push_back(32'h0);
    bus_read(A_STATUS, d, e);
    got = d & 32'h80; want = exp_q.pop_front(); n_checks++;
    if (got !== want) $display("FAIL pe_w1c_sticky: got %h expected %h", got, want);
    else n_pass++;
    wr(A_INTEN, 32'h0);
  endtask

`ifdef UART_RX_TIMEOUT_EN
  task automatic test_timeout;
    logic [31:0] d; logic e;
    wr(A_INTST, 32'h3F);
    wr(A_TO, 32'h04);
    push_byte(8'h5A);
    idle(4);
    repeat (3) tick();
    exp_q.push_back(32'h0);
    bus_read(A_INTST, d, e);
    got = d & 32'h20; want = exp_q.pop_front(); n_checks++;
    if (got !== want) $display("FAIL timeout_early: got %h expected %h", got, want);
    else n_pass++;

    tick();
    exp_q.push_back(32'h20);
    bus_read(A_INTST, d, e);
    got = d & 32'h20; want = exp_q.pop_front(); n_checks++;
    if (got !== want) $display("FAIL timeout_fire: got %h expected %h", got, want);
    else n_pass++;

    exp_q.push_back(32'h0000_015A);
    bus_read(A_RX, d, e);
    got = d; want = exp_q.pop_front(); n_checks++;
    if (got !== want) $display("FAIL timeout_rx_read: got %h expected %h", got, want);
    else n_pass++;

    wr(A_INTST, 32'h20);
    repeat (5) tick();
    exp_q.push_back(32'h0);
    bus_read(A_INTST, d, e);
    got = d & 32'h20; want = exp_q.pop_front(); n_checks++;
    if (got !== want) $display("FAIL timeout_cleared: got %h expected %h", got, want);
    else n_pass++;
    wr(A_TO, 32'h0);
  endtask
`endif

  task automatic test_reset_mid;
    logic [31:0] d; logic e;
    push_byte(8'h99);
    idle(4);
    @(posedge uart_clk); #1; rst = 1'b1;
    @(negedge uart_clk);
    exp_q.push_back(32'd0);
    got = {31'd0, rd_en}; want = exp_q.pop_front(); n_checks++;
    if (got !== want) $display("FAIL mid_reset_rden: got %h expected %h", got, want);
    else n_pass++;
    @(posedge uart_clk); #1; rst = 1'b0;

    exp_q.push_back(32'h8000_0000);
    bus_read(A_RX, d, e);
    got = {e, d[30:0]}; want = exp_q.pop_front(); n_checks++;
    if (got !== want) $display("FAIL mid_reset_hold: got %h expected %h", got, want);
    else n_pass++;

    exp_q.push_back(32'h0000_000C);
    bus_read(A_CTRL, d, e);
    got = d; want = exp_q.pop_front(); n_checks++;
    if (got !== want) $display("FAIL mid_reset_ctrl: got %h expected %h", got, want);
    else n_pass++;
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge uart_clk);
    #1 rst = 1'b0;
    test_reset();
    test_ctrl_baud();
    test_tx();
    test_rx_single();
    test_back_to_back();
    test_errors();
    test_fifo_ctrl();
    test_watermarks();
    test_parity_irq();
`ifdef UART_RX_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
